// File: rtl/pipeline_defs_pkg.sv
// pipeline_defs: opcodes, functs, ALU encodings, extend modes and ex_ctrl bit positions shared by the ID stage
package pipeline_defs;
   localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05;
   localparam logic [5:0] OP_ADDI = 6'h08, OP_SLTI = 6'h0A, OP_ANDI = 6'h0C, OP_ORI = 6'h0D;
   localparam logic [5:0] OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B;
   localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A;
   typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_LUI} alu_op_e;
   typedef enum logic [1:0] {EXT_SIGN, EXT_ZERO, EXT_LUI, EXT_JUMP} ext_e;
   localparam int C_REG_WRITE = 9, C_MEM_READ = 8, C_MEM_WRITE = 7, C_ALU_SRC = 6;
   localparam int C_BRANCH = 5, C_BNE = 4, C_JUMP = 3;
endpackage

// File: rtl/control_decoder.sv
// control_decoder: combinational opcode/funct to ex_ctrl, immediate extend mode and illegal flag
module control_decoder
   import pipeline_defs::*;
(
   input  logic [5:0] i_opcode,
   input  logic [5:0] i_funct,
   output logic [9:0] o_ctrl,
   output ext_e       o_ext,
   output logic       o_rtype,
   output logic       o_rt_read,
   output logic       o_illegal
);
   logic w_rw, w_mr, w_mw, w_src, w_br, w_bne, w_jmp;
   alu_op_e w_alu;
   always_comb begin
      w_rw = 1'b0;
      w_mr = 1'b0;
      w_mw = 1'b0;
      w_src = 1'b0;
      w_br = 1'b0;
      w_bne = 1'b0;
      w_jmp = 1'b0;
      w_alu = ALU_ADD;
      o_ext = EXT_SIGN;
      o_rtype = 1'b0;
      o_rt_read = 1'b0;
      o_illegal = 1'b0;
      case (i_opcode)
         OP_RTYPE: begin
            w_rw = 1'b1;
            o_rtype = 1'b1;
            o_rt_read = 1'b1;
            case (i_funct)
               FN_ADD:  w_alu = ALU_ADD;
               FN_SUB:  w_alu = ALU_SUB;
               FN_AND:  w_alu = ALU_AND;
               FN_OR:   w_alu = ALU_OR;
               FN_SLT:  w_alu = ALU_SLT;
               default: o_illegal = 1'b1;
            endcase
         end
         OP_ADDI: begin w_rw = 1'b1; w_src = 1'b1; end
         OP_SLTI: begin w_rw = 1'b1; w_src = 1'b1; w_alu = ALU_SLT; end
         OP_ANDI: begin w_rw = 1'b1; w_src = 1'b1; w_alu = ALU_AND; o_ext = EXT_ZERO; end
         OP_ORI:  begin w_rw = 1'b1; w_src = 1'b1; w_alu = ALU_OR; o_ext = EXT_ZERO; end
         OP_LUI:  begin w_rw = 1'b1; w_src = 1'b1; w_alu = ALU_LUI; o_ext = EXT_LUI; end
         OP_LW:   begin w_rw = 1'b1; w_mr = 1'b1; w_src = 1'b1; end
         OP_SW:   begin w_mw = 1'b1; w_src = 1'b1; o_rt_read = 1'b1; end
         OP_BEQ:  begin w_br = 1'b1; w_alu = ALU_SUB; o_rt_read = 1'b1; end
         OP_BNE:  begin w_br = 1'b1; w_bne = 1'b1; w_alu = ALU_SUB; o_rt_read = 1'b1; end
         OP_J:    begin w_jmp = 1'b1; o_ext = EXT_JUMP; end
         default: o_illegal = 1'b1;
      endcase
   end
   assign o_ctrl = {w_rw, w_mr, w_mw, w_src, w_br, w_bne, w_jmp, w_alu};
endmodule

// File: rtl/decode_stage.sv
// decode_stage: MIPS ID stage with IF/ID register, write-back bypass, load-use stall and ID/EX register
module decode_stage
   import pipeline_defs::*;
#(
   parameter int DATA_W = 32,
   parameter int PC_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_valid,
   input  logic [31:0]       if_instr,
   input  logic [PC_W-1:0]   if_pc4,
   output logic              id_stall,
   input  logic              flush,
   output logic [4:0]        read_reg1,
   output logic [4:0]        read_reg2,
   input  logic [DATA_W-1:0] busA,
   input  logic [DATA_W-1:0] busB,
   input  logic              wb_we,
   input  logic [4:0]        wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic              ex_valid,
   output logic [PC_W-1:0]   ex_pc4,
   output logic [DATA_W-1:0] ex_opA,
   output logic [DATA_W-1:0] ex_opB,
   output logic [DATA_W-1:0] ex_imm,
   output logic [4:0]        ex_rs,
   output logic [4:0]        ex_rt,
   output logic [4:0]        ex_dst,
   output logic [9:0]        ex_ctrl,
   output logic              ex_illegal
);
   logic r_v, r_cwe;
   logic [31:0] r_instr;
   logic [PC_W-1:0] r_pc4;
   logic [4:0] r_caddr;
   logic [DATA_W-1:0] r_cdata;
   logic [4:0] w_rs, w_rt, w_rd, w_dst;
   logic [9:0] w_ctrl;
   ext_e w_ext;
   logic w_rtype, w_rt_read, w_illegal, w_kill;
   logic [DATA_W-1:0] w_opA, w_opB, w_imm;
   assign w_rs = r_instr[25:21];
   assign w_rt = r_instr[20:16];
   assign w_rd = r_instr[15:11];
   control_decoder u_dec (
      .i_opcode  (r_instr[31:26]),
      .i_funct   (r_instr[5:0]),
      .o_ctrl    (w_ctrl),
      .o_ext     (w_ext),
      .o_rtype   (w_rtype),
      .o_rt_read (w_rt_read),
      .o_illegal (w_illegal)
   );
   assign id_stall = r_v && ex_valid && ex_ctrl[C_MEM_READ] && ex_dst != 5'd0 &&
                     (ex_dst == w_rs || (w_rt_read && ex_dst == w_rt));
   assign read_reg1 = id_stall ? w_rs : if_instr[25:21];
   assign read_reg2 = id_stall ? w_rt : if_instr[20:16];
   // Capture catches a write on the bank read edge, which the registered bank read misses
   assign w_opA = (w_rs == 5'd0) ? '0 : (wb_we && wb_addr == w_rs) ? wb_data :
                  (r_cwe && r_caddr == w_rs) ? r_cdata : busA;
   assign w_opB = (w_rt == 5'd0) ? '0 : (wb_we && wb_addr == w_rt) ? wb_data :
                  (r_cwe && r_caddr == w_rt) ? r_cdata : busB;
   assign w_imm = (w_ext == EXT_ZERO) ? DATA_W'(r_instr[15:0]) :
                  (w_ext == EXT_LUI)  ? DATA_W'({r_instr[15:0], 16'h0000}) :
                  (w_ext == EXT_JUMP) ? DATA_W'(r_instr[25:0]) :
                  {{(DATA_W-16){r_instr[15]}}, r_instr[15:0]};
   assign w_dst = !w_ctrl[C_REG_WRITE] ? 5'd0 : w_rtype ? w_rd : w_rt;
   assign w_kill = flush || id_stall || !r_v;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_v <= 1'b0;
         r_instr <= '0;
         r_pc4 <= '0;
         r_cwe <= 1'b0;
         r_caddr <= '0;
         r_cdata <= '0;
         ex_valid <= 1'b0;
         ex_illegal <= 1'b0;
         ex_pc4 <= '0;
         ex_opA <= '0;
         ex_opB <= '0;
         ex_imm <= '0;
         ex_rs <= '0;
         ex_rt <= '0;
         ex_dst <= '0;
         ex_ctrl <= '0;
      end else begin
         r_cwe <= wb_we;
         r_caddr <= wb_addr;
         r_cdata <= wb_data;
         if (flush) r_v <= 1'b0;
         else if (!id_stall) begin
            r_v <= if_valid;
            r_instr <= if_instr;
            r_pc4 <= if_pc4;
         end
         ex_valid <= !w_kill && !w_illegal;
         ex_illegal <= !w_kill && w_illegal;
         ex_pc4 <= (w_kill || w_illegal) ? '0 : r_pc4;
         ex_opA <= (w_kill || w_illegal) ? '0 : w_opA;
         ex_opB <= (w_kill || w_illegal) ? '0 : w_opB;
         ex_imm <= (w_kill || w_illegal) ? '0 : w_imm;
         ex_rs <= (w_kill || w_illegal) ? '0 : w_rs;
         ex_rt <= (w_kill || w_illegal) ? '0 : w_rt;
         ex_dst <= (w_kill || w_illegal) ? '0 : w_dst;
         ex_ctrl <= (w_kill || w_illegal) ? '0 : w_ctrl;
      end
   end
endmodule
